// File: rtl/blake_digest_out.sv
// BLAKE-512 finalization/readout: folds v and salt into the chaining value,
// presents it for write-back and, on the last block, streams it word by word.
module blake_digest_out #(
  parameter int W  = 64,
  parameter int NW = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              last,
  input  logic [NW*W-1:0]   h,
  input  logic [2*NW*W-1:0] v,
  input  logic [4*W-1:0]    s,
  output logic [NW*W-1:0]   hnew,
  output logic              hupd,
  output logic [W-1:0]      dout,
  output logic              dvalid,
  input  logic              dready,
  output logic              busy,
  output logic              done
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [NW*W-1:0] hnew_q;
  logic [NW*W-1:0] hnew_d;
  logic            hupd_q;
  logic            done_q;
  logic            last_word;
  logic [W-1:0]    words [NW];

  // h'[i] = h[i] ^ s[i mod 4] ^ v[i] ^ v[i+NW]; pure XOR, no carries
  function automatic logic [NW*W-1:0] finalize(input logic [NW*W-1:0]   hv,
                                               input logic [2*NW*W-1:0] vv,
                                               input logic [4*W-1:0]    sv);
    logic [NW*W-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      r[i*W +: W] = hv[i*W +: W] ^ sv[(i % 4)*W +: W] ^ vv[i*W +: W] ^ vv[(i+NW)*W +: W];
    end
    return r;
  endfunction

  assign hnew_d    = finalize(h, v, s);
  assign last_word = (idx_q == IW'(NW-1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hnew_q  <= '0;
      hupd_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      hupd_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hnew_q <= hnew_d;
            hupd_q <= 1'b1;
            idx_q  <= '0;
            if (last) state_q <= SEND;
          end
        end
        SEND: begin
          // start is deliberately ignored here; the stream owns hnew until done
          if (dready) begin
            if (last_word) begin
              idx_q   <= '0;
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) words[i] = hnew_q[i*W +: W];
  end

  // dvalid/busy decode the state register only, so dready never reaches them
  assign dout   = words[idx_q];
  assign dvalid = (state_q == SEND);
  assign busy   = (state_q == SEND);
  assign hnew   = hnew_q;
  assign hupd   = hupd_q;
  assign done   = done_q;

endmodule

// File: tb/tb_blake_digest_out.sv
// Randomized self-checking bench for blake_digest_out against a word-array model.
module tb_blake_digest_out;
  localparam int W  = 64;
  localparam int NW = 8;

  logic              clk = 1'b0;
  logic              rstb;
  logic              start, last, dready;
  logic [NW*W-1:0]   h;
  logic [2*NW*W-1:0] v;
  logic [4*W-1:0]    s;
  logic [NW*W-1:0]   hnew;
  logic              hupd, dvalid, busy, done;
  logic [W-1:0]      dout;

  blake_digest_out #(.W(W), .NW(NW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .last(last),
    .h(h), .v(v), .s(s), .hnew(hnew), .hupd(hupd), .dout(dout),
    .dvalid(dvalid), .dready(dready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]    hw [NW];
  logic [W-1:0]    vw [2*NW];
  logic [W-1:0]    sw [4];
  logic [W-1:0]    exp_d [NW];
  logic [NW*W-1:0] exp_hnew;
  logic [W-1:0]    got_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: digest word i is the XOR of h[i], salt[i mod 4], v[i], v[i+8]
  task automatic apply_and_model();
    for (int i = 0; i < NW; i++) h[i*W +: W] = hw[i];
    for (int i = 0; i < 2*NW; i++) v[i*W +: W] = vw[i];
    for (int j = 0; j < 4; j++) s[j*W +: W] = sw[j];
    for (int i = 0; i < NW; i++) begin
      exp_d[i] = hw[i] ^ sw[i % 4] ^ vw[i] ^ vw[i + NW];
      exp_hnew[i*W +: W] = exp_d[i];
    end
  endtask

  task automatic randomize_words();
    for (int i = 0; i < NW; i++) hw[i] = {$urandom, $urandom};
    for (int i = 0; i < 2*NW; i++) vw[i] = {$urandom, $urandom};
    for (int j = 0; j < 4; j++) sw[j] = {$urandom, $urandom};
  endtask

  task automatic pulse_start(input logic is_last);
    apply_and_model();
    start = 1'b1;
    last  = is_last;
    tick();
    start = 1'b0;
    last  = 1'b0;
  endtask

  // Drives dready (0: always 1, 1: alternating from 1, 2: random), records
  // transferred words, counts dout/dvalid instability under backpressure.
  task automatic drain(input int mode, output int ticks, output int stable_err,
                       output bit timed_out);
    logic [W-1:0] held;
    bit           holding;
    ticks = 0; stable_err = 0; timed_out = 1'b0;
    while (1) begin
      case (mode)
        0:       dready = 1'b1;
        1:       dready = (ticks % 2 == 0);
        default: dready = 1'($urandom_range(0, 1));
      endcase
      holding = dvalid && !dready;
      held    = dout;
      if (dvalid && dready) got_q.push_back(dout);
      tick();
      ticks++;
      if (holding && (dout !== held || dvalid !== 1'b1)) stable_err++;
      if (done) break;
      if (ticks > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
    dready = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b0; start = 0; last = 0; dready = 0; h = '0; v = '0; s = '0;
    tick(); tick();
    checks++;
    if ({hnew, hupd, dvalid, busy, done, dout} !== '0) begin
      failures++; $display("FAIL reset_initial outputs=%h required=0", {hnew, hupd, dvalid, busy, done, dout});
    end
    rstb = 1'b1;
    tick();
    randomize_words();
    pulse_start(1'b1);
    tick();
    #2 rstb = 1'b0;
    #1;
    checks++;
    if ({hnew, hupd, dvalid, busy, done, dout} !== '0) begin
      failures++; $display("FAIL reset_midrun outputs=%h required=0", {hnew, hupd, dvalid, busy, done, dout});
    end
    tick();
    rstb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({hnew, hupd, dvalid, busy, done} !== '0) begin
        failures++; $display("FAIL reset_quiet cycle=%0d outputs=%h required=0", k, {hnew, hupd, dvalid, busy, done});
      end
    end
  endtask

  task automatic test_nonfinal();
    for (int i = 0; i < NW; i++) hw[i] = '0;
    for (int j = 0; j < 4; j++) sw[j] = '0;
    for (int k = 0; k < 2*NW; k++) vw[k] = W'(k);
    pulse_start(1'b0);
    checks++;
    if (hupd !== 1'b1) begin failures++; $display("FAIL nonfinal_hupd got=%b required=1", hupd); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (hnew[i*W +: W] !== 64'd8) begin
        failures++; $display("FAIL nonfinal_word%0d got=%h required=8", i, hnew[i*W +: W]);
      end
    end
    checks++;
    if (dvalid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL nonfinal_stream dvalid=%b busy=%b required=0/0", dvalid, busy);
    end
    vw[0] = 64'hFFFF; apply_and_model();  // inputs change without start: hnew must hold
    tick();
    checks++;
    if (hupd !== 1'b0 || hnew[0 +: W] !== 64'd8) begin
      failures++; $display("FAIL nonfinal_hold hupd=%b word0=%h required=0/8", hupd, hnew[0 +: W]);
    end
  endtask

  task automatic test_back_to_back();
    logic [NW*W-1:0] first;
    randomize_words();
    pulse_start(1'b0);
    first = exp_hnew;
    checks++;
    if (hupd !== 1'b1 || hnew !== first) begin
      failures++; $display("FAIL b2b_first hupd=%b hnew=%h required=%h", hupd, hnew, first);
    end
    randomize_words();
    pulse_start(1'b0);
    checks++;
    if (hupd !== 1'b1 || hnew !== exp_hnew) begin
      failures++; $display("FAIL b2b_second hupd=%b hnew=%h required=%h", hupd, hnew, exp_hnew);
    end
  endtask

  task automatic check_stream(input string name, input int ticks, input int stable_err,
                              input bit timed_out, input int want_ticks);
    checks++;
    if (timed_out) begin failures++; $display("FAIL %s_timeout ticks=%0d", name, ticks); end
    checks++;
    if (got_q.size() != NW) begin
      failures++; $display("FAIL %s_count got=%0d required=%0d", name, got_q.size(), NW);
    end else begin
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (got_q[i] !== exp_d[i]) begin
          failures++; $display("FAIL %s_word%0d got=%h required=%h", name, i, got_q[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (stable_err != 0) begin failures++; $display("FAIL %s_stable errors=%0d required=0", name, stable_err); end
    if (want_ticks > 0) begin
      checks++;
      if (ticks != want_ticks) begin failures++; $display("FAIL %s_latency got=%0d required=%0d", name, ticks, want_ticks); end
    end
    checks++;
    if (done !== 1'b1 || dvalid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_end done=%b dvalid=%b busy=%b required=1/0/0", name, done, dvalid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b required=0", name, done); end
  endtask

  task automatic test_final();
    int t, se; bit to;
    for (int i = 0; i < NW; i++) hw[i] = 64'h100 + W'(i);
    for (int j = 0; j < 4; j++) sw[j] = '0;
    for (int k = 0; k < 2*NW; k++) vw[k] = '0;
    pulse_start(1'b1);
    checks++;
    if (hupd !== 1'b1 || dvalid !== 1'b1 || busy !== 1'b1 || dout !== 64'h100) begin
      failures++; $display("FAIL final_first hupd=%b dvalid=%b busy=%b dout=%h required=1/1/1/100", hupd, dvalid, busy, dout);
    end
    got_q.delete();
    drain(0, t, se, to);
    check_stream("final", t, se, to, NW);
  endtask

  task automatic test_salt_backpressure();
    int t, se; bit to;
    for (int i = 0; i < NW; i++) hw[i] = '0;
    for (int k = 0; k < 2*NW; k++) vw[k] = '0;
    sw[0] = 64'hA; sw[1] = 64'hB; sw[2] = 64'hC; sw[3] = 64'hD;
    pulse_start(1'b1);
    got_q.delete();
    drain(1, t, se, to);
    check_stream("salt_bp", t, se, to, 0);
  endtask

  task automatic test_start_during_send();
    int t, se; bit to;
    logic [NW*W-1:0] orig;
    logic [W-1:0]    orig_d [NW];
    randomize_words();
    pulse_start(1'b1);
    orig = exp_hnew;
    for (int i = 0; i < NW; i++) orig_d[i] = exp_d[i];
    got_q.delete();
    dready = 1'b1;
    for (int k = 0; k < 3; k++) begin got_q.push_back(dout); tick(); end
    randomize_words();
    apply_and_model();
    start = 1'b1; last = 1'b1;
    got_q.push_back(dout);
    tick();
    start = 1'b0; last = 1'b0;
    checks++;
    if (hupd !== 1'b0 || hnew !== orig) begin
      failures++; $display("FAIL send_start_ignored hupd=%b hnew=%h required=0/%h", hupd, hnew, orig);
    end
    for (int i = 0; i < NW; i++) exp_d[i] = orig_d[i];
    drain(0, t, se, to);
    check_stream("send_start", t, se, to, NW - 4);
    checks++;
    if (dvalid !== 1'b0 || hupd !== 1'b0) begin
      failures++; $display("FAIL send_start_after dvalid=%b hupd=%b required=0/0", dvalid, hupd);
    end
  endtask

  task automatic test_reset_midstream();
    int t, se; bit to;
    bit saw_done;
    randomize_words();
    pulse_start(1'b1);
    dready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    dready = 1'b0;
    checks++;
    if (dout !== exp_d[3]) begin failures++; $display("FAIL midrst_word3 got=%h required=%h", dout, exp_d[3]); end
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (dvalid !== 1'b0 || busy !== 1'b0 || dout !== '0 || hnew !== '0) begin
      failures++; $display("FAIL midrst_clear dvalid=%b busy=%b dout=%h required=0/0/0", dvalid, busy, dout);
    end
    saw_done = 1'b0;
    tick();
    if (done) saw_done = 1'b1;
    rstb = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); if (done) saw_done = 1'b1; end
    checks++;
    if (saw_done) begin failures++; $display("FAIL midrst_no_done got=1 required=0"); end
    randomize_words();
    pulse_start(1'b1);
    got_q.delete();
    drain(0, t, se, to);
    check_stream("midrst_restart", t, se, to, NW);
  endtask

  task automatic test_random();
    int t, se; bit to;
    for (int it = 0; it < 12; it++) begin
      randomize_words();
      pulse_start(1'($urandom_range(0, 1)));
      checks++;
      if (hupd !== 1'b1 || hnew !== exp_hnew) begin
        failures++; $display("FAIL rand%0d_hnew got=%h required=%h", it, hnew, exp_hnew);
      end
      if (dvalid) begin
        got_q.delete();
        drain(2, t, se, to);
        check_stream("rand", t, se, to, 0);
      end else begin
        tick();
        checks++;
        if (dvalid !== 1'b0 || hupd !== 1'b0 || hnew !== exp_hnew) begin
          failures++; $display("FAIL rand%0d_idle dvalid=%b hupd=%b", it, dvalid, hupd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonfinal();
    test_back_to_back();
    test_final();
    test_salt_backpressure();
    test_start_during_send();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
